vector_mul_seq: RTL and testbench
=================================

VECTOR_MUL_SEQ -- requirements
Module: vector_mul_seq

Interface
REQ-001 SHALL have parameter VEC_LEN, default 100, meaning the number of elements per run (2..128).
REQ-002 SHALL have parameter DIV_A, default 50000000, meaning the signed pre-scale divisor for a; nonzero.
REQ-003 SHALL have parameter DIV_B, default 43, meaning the signed pre-scale divisor for b; nonzero.
REQ-004 SHALL have parameter ADDR_W, default 7, meaning the element index width; 2^ADDR_W >= VEC_LEN.
REQ-005 SHALL have port clk, input, 1 bit, meaning the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit, meaning synchronous active-high reset.
REQ-007 SHALL have port start, input, 1 bit, meaning begin a run; sampled only in IDLE.
REQ-008 SHALL have port abort, input, 1 bit, meaning cancel the current run.
REQ-009 SHALL have port rd_en, output, 1 bit, meaning an operand read request.
REQ-010 SHALL have port rd_addr, output, ADDR_W bits, meaning the operand element index.
REQ-011 SHALL have ports a_data and b_data, input, 32 bits signed each, meaning operands valid exactly 1 cycle after rd_en.
REQ-012 SHALL have port wr_en, output, 1 bit, meaning result write valid.
REQ-013 SHALL have port wr_addr, output, ADDR_W bits, meaning the result element index.
REQ-014 SHALL have port wr_data, output, 32 bits signed, meaning the result value.
REQ-015 SHALL have port wr_ready, input, 1 bit, meaning the sink accepts the write when high in the same cycle as wr_en.
REQ-016 SHALL have port busy, output, 1 bit, meaning a run is in progress.
REQ-017 SHALL have port done, output, 1 bit, meaning a one-cycle pulse when a run completes.

Function
REQ-018 SHALL implement FSM states IDLE, READ, CALC, WRITE, DONE.
REQ-019 IDLE: start=1 and abort=0 SHALL clear idx to 0 and go to READ; otherwise SHALL stay in IDLE.
REQ-020 READ: SHALL assert rd_en=1 with rd_addr=idx for exactly one cycle, then go to CALC.
REQ-021 CALC: SHALL register prod = (a_data / DIV_A) * (b_data / DIV_B), then go to WRITE.
REQ-022 Division SHALL be signed and truncate toward zero; the product SHALL be the low 32 bits of the signed product.
REQ-023 Only one shared divider/multiplier lane SHALL exist; elements are processed strictly in order 0..VEC_LEN-1.
REQ-024 WRITE: SHALL hold wr_en=1, wr_addr=idx, wr_data=prod stable until wr_ready=1.
REQ-025 WRITE with wr_ready=1: if idx==VEC_LEN-1 SHALL go to DONE; else SHALL increment idx and go to READ.
REQ-026 DONE: done=1 for one cycle, then SHALL go to IDLE; start in DONE SHALL be ignored.
REQ-027 busy SHALL be 1 exactly in READ, CALC, WRITE.
REQ-028 Latency: with wr_ready held high and start sampled in cycle 0, element i write SHALL occur in cycle 3i+3 and done in cycle 3*VEC_LEN+1.
REQ-029 start while busy or in DONE SHALL be ignored, with no restart and no idx change.
REQ-030 abort=1 in READ/CALC/WRITE SHALL go to IDLE next cycle, with no done pulse and wr_en low from that cycle.
REQ-031 Simultaneous start and abort in IDLE: abort SHALL win and the block SHALL stay IDLE.
REQ-032 abort in WRITE with wr_ready=1 SHALL complete that write; abort SHALL still return the block to IDLE with no done pulse.
REQ-033 rd_addr and wr_addr SHALL never exceed VEC_LEN-1.

Reset
REQ-034 rst=1 SHALL force IDLE, idx=0, prod=0, and rd_en=wr_en=busy=done=0 with rd_addr=wr_addr=wr_data=0 at the next edge, overriding all inputs.
REQ-035 rst mid-run SHALL discard the run; the next start SHALL begin again at element 0.

Verification
REQ-036 Scenario: a=100000000, b=86, wr_ready=1 -> every wr_data=4; done in cycle 301 for VEC_LEN=100.
REQ-037 Scenario: a=-150000000, b=-129 -> wr_data=9; a=49999999, b=43 -> wr_data=0.
REQ-038 Scenario: a=-2147483648, b=-2147483648 -> wr_data=2097542160 (-42 * -49941480).
REQ-039 Scenario: wr_ready low 5 cycles at element 7 -> wr_en/wr_addr=7/wr_data held stable; no rd_en; element 8 read follows acceptance.
REQ-040 Scenario: abort in CALC of element 50 -> IDLE next cycle, no done, no write to 50; new start writes from element 0.
REQ-041 Scenario: rst in WRITE of element 20, and start pulsed while busy -> outputs zero after rst; busy-time start causes no effect.

Source files
------------

// File: rtl/vector_mul_seq.sv
// vector_mul_seq: sequential per-element (a/DIV_A)*(b/DIV_B) over VEC_LEN operands with a single shared arithmetic lane
module vector_mul_seq #(
  parameter int VEC_LEN = 100,
  parameter int DIV_A   = 50000000,
  parameter int DIV_B   = 43,
  parameter int ADDR_W  = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  output logic                     rd_en,
  output logic [ADDR_W-1:0]        rd_addr,
  input  logic signed [31:0]       a_data,
  input  logic signed [31:0]       b_data,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic signed [31:0]       wr_data,
  input  logic                     wr_ready,
  output logic                     busy,
  output logic                     done
);
  typedef enum logic [2:0] {IDLE, READ, CALC, WRITE, DONE} state_t;
  localparam logic signed [31:0] da = DIV_A;
  localparam logic signed [31:0] db = DIV_B;
  localparam logic [ADDR_W-1:0] last = ADDR_W'(VEC_LEN - 1);
  state_t state, state_n;
  logic [ADDR_W-1:0] idx, idx_n;
  logic signed [31:0] prod, prod_n, qa, qb;
  assign qa = a_data / da;
  assign qb = b_data / db;
  always_comb begin
    state_n = state;
    idx_n = idx;
    prod_n = prod;
    unique case (state)
      IDLE: if (start && !abort) begin
        state_n = READ;
        idx_n = '0;
      end
      READ: state_n = abort ? IDLE : CALC;
      CALC: begin
        state_n = abort ? IDLE : WRITE;
        prod_n = qa * qb;
      end
      WRITE: if (abort) state_n = IDLE;
        else if (wr_ready) begin
          state_n = (idx == last) ? DONE : READ;
          idx_n = (idx == last) ? idx : idx + 1'b1;
        end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      prod <= '0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      prod <= prod_n;
    end
  end
  // addresses and data are gated so idle outputs stay zero and in range
  assign rd_en = state == READ;
  assign rd_addr = rd_en ? idx : '0;
  assign wr_en = state == WRITE;
  assign wr_addr = wr_en ? idx : '0;
  assign wr_data = wr_en ? prod : '0;
  assign busy = rd_en || wr_en || state == CALC;
  assign done = state == DONE;
endmodule

// File: tb/tb_vector_mul_seq.sv
// tb_vector_mul_seq: directed + randomized checks of vector_mul_seq against an arithmetic reference
module tb_vector_mul_seq;
  localparam int N = 100, DA = 50000000, DB = 43, AW = 7;
  logic clk = 0, rst, start, abort, rd_en, wr_en, wr_ready, busy, done;
  logic [AW-1:0] rd_addr, wr_addr;
  logic signed [31:0] a_data, b_data, wr_data;
  int amem[N], bmem[N];
  int n_cmp = 0, n_bad = 0, cyc = 0, cyc0 = 0, exp_idx = 0, n_done = 0, done_rel = 0, last_acc = -1;
  bit timing = 0;
  bit ok;
  always #5 clk = ~clk;
  vector_mul_seq #(.VEC_LEN(N), .DIV_A(DA), .DIV_B(DB), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .rd_en(rd_en), .rd_addr(rd_addr),
    .a_data(a_data), .b_data(b_data), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .busy(busy), .done(done)
  );
  function automatic int model(int a, int b);
    return (a / DA) * (b / DB);
  endfunction
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // one clock: score the current cycle, advance, then serve operands requested last cycle
  task automatic tick();
    logic p;
    logic [AW-1:0] pa;
    last_acc = -1;
    if (wr_en && wr_ready) begin
      chk("wr_addr", wr_addr, exp_idx);
      chk("wr_data", wr_data, model(amem[exp_idx % N], bmem[exp_idx % N]));
      if (timing) chk("wr_cycle", cyc - cyc0, 3 * exp_idx + 3);
      last_acc = wr_addr;
      exp_idx++;
    end
    if (done) begin
      n_done++;
      done_rel = cyc - cyc0;
    end
    if (rd_en) chk("rd_range", rd_addr <= AW'(N - 1), 1);
    p = rd_en;
    pa = rd_addr;
    @(posedge clk);
    #1;
    cyc++;
    if (p) begin
      a_data = amem[pa % N];
      b_data = bmem[pa % N];
    end else begin
      a_data = $urandom;
      b_data = $urandom;
    end
  endtask
  task automatic begin_run();
    exp_idx = 0;
    n_done = 0;
    cyc0 = cyc;
    start = 1;
    tick();
    start = 0;
  endtask
  task automatic finish_run(int mode, int budget);
    int n = 0, stall = 0;
    while (n_done == 0 && n < budget) begin
      start = done || ((cyc - cyc0) % 17 == 5);
      if (mode == 1) wr_ready = 1'($urandom_range(0, 1));
      else if (mode == 2 && wr_en && wr_addr == 7 && stall < 5) begin
        wr_ready = 0;
        stall++;
        chk("hold_data", wr_data, model(amem[7], bmem[7]));
        chk("hold_no_rd", rd_en, 0);
      end else wr_ready = 1;
      tick();
      n++;
      if (mode == 2 && last_acc == 7) begin
        chk("rd_after7", rd_en, 1);
        chk("rd_addr8", rd_addr, 8);
      end
    end
    start = 0;
    chk("run_done", n_done, 1);
    chk("run_writes", exp_idx, N);
    chk("idle_after_done", busy, 0);
    if (mode == 0) chk("done_cycle", done_rel, 3 * N + 1);
    if (mode == 2) chk("stall_cycles", stall, 5);
    tick();
    chk("start_in_done_ignored", busy, 0);
  endtask
  task automatic wait_for(bit rd, int addr);
    ok = 0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      if (rd ? (rd_en && rd_addr == AW'(addr)) : (wr_en && wr_addr == AW'(addr))) ok = 1;
      else begin
        wr_ready = 1;
        tick();
      end
    end
    chk("reach_point", ok, 1);
  endtask
  task automatic fill_random();
    for (int i = 0; i < N; i++) begin
      amem[i] = $urandom;
      bmem[i] = (i % 3 == 0) ? int'($urandom_range(0, 4000)) - 2000 : int'($urandom);
    end
  endtask
  initial begin
    rst = 1; start = 0; abort = 0; wr_ready = 0; a_data = 0; b_data = 0;
    repeat (3) tick();
    chk("rst_rd_en", rd_en, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    rst = 0;
    start = 1; abort = 1;
    tick();
    start = 0; abort = 0;
    chk("start_abort_busy", busy, 0);
    tick();
    chk("start_abort_rd", rd_en, 0);
    for (int i = 0; i < N; i++) begin
      amem[i] = 100000000;
      bmem[i] = 86;
    end
    begin_run();
    timing = 1;
    finish_run(0, 400);
    timing = 0;
    fill_random();
    amem[0] = -150000000; bmem[0] = -129;
    amem[1] = 49999999;   bmem[1] = 43;
    amem[2] = int'(32'h8000_0000); bmem[2] = int'(32'h8000_0000);
    begin_run();
    finish_run(1, 2000);
    fill_random();
    begin_run();
    finish_run(2, 600);
    fill_random();
    begin_run();
    wait_for(1, 50);
    wr_ready = 1;
    tick();
    abort = 1;
    tick();
    abort = 0;
    chk("abort_busy", busy, 0);
    chk("abort_wr_en", wr_en, 0);
    chk("abort_done", done, 0);
    repeat (5) tick();
    chk("abort_no_done", n_done, 0);
    chk("abort_writes", exp_idx, 50);
    begin_run();
    timing = 1;
    finish_run(0, 400);
    timing = 0;
    begin_run();
    wait_for(0, 30);
    wr_ready = 1; abort = 1;
    tick();
    abort = 0;
    chk("abort_wr_completes", exp_idx, 31);
    chk("abort_wr_busy", busy, 0);
    tick();
    chk("abort_wr_no_done", n_done, 0);
    fill_random();
    begin_run();
    wait_for(0, 20);
    wr_ready = 0; start = 1;
    tick();
    start = 0;
    chk("busy_start_wr_en", wr_en, 1);
    chk("busy_start_wr_addr", wr_addr, 20);
    rst = 1;
    tick();
    rst = 0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_wr_en", wr_en, 0);
    chk("mid_rst_wr_addr", wr_addr, 0);
    chk("mid_rst_wr_data", wr_data, 0);
    chk("mid_rst_rd_en", rd_en, 0);
    tick();
    chk("mid_rst_stays_idle", busy, 0);
    begin_run();
    timing = 1;
    finish_run(0, 400);
    timing = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
